// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Holds the channel limit, default divisor and divisor-channel index width.
package clkdiv_pkg;

   localparam int CLKDIV_MAX_CH = 16;
   localparam int unsigned CLKDIV_DEF_DIV = 250000;

   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Divisor write bus: strobe, channel, value out; reject pulse back.
// master drives div_wr/div_ch/div_val, slave returns div_err.
interface clkdiv_multi_if
   import clkdiv_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 31
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   logic             div_wr;
   logic [CH_W-1:0]  div_ch;
   logic [CNT_W-1:0] div_val;
   logic             div_err;

   modport master (
      output div_wr, div_ch, div_val,
      input  div_err
   );

   modport slave (
      input  div_wr, div_ch, div_val,
      output div_err
   );

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/shadow divisor, tick and toggle.
// Ports: sys_clk, sys_rst, i_en, i_sync, i_wr, i_val -> o_tick, o_cclk.
module clkdiv_chan #(
   parameter int               CNT_W   = 31,
   parameter logic [CNT_W-1:0] DEF_DIV = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_val,
   output logic             o_tick,
   output logic             o_cclk
);

   localparam logic [CNT_W-1:0] ONE = 1;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_act;
   logic [CNT_W-1:0] r_shd;
   logic             r_pend;
   logic             r_tick;
   logic             r_cclk;

   logic             w_wrap;
   logic             w_clr;
   logic             w_load;
   logic [CNT_W-1:0] w_nxt_div;

   assign w_wrap    = i_en && (r_cnt == r_act - ONE);
   assign w_clr     = !i_en || i_sync;
   // A write landing on a wrap/clear edge takes effect right away
   assign w_nxt_div = i_wr ? i_val : r_shd;
   assign w_load    = (w_wrap || w_clr) && (i_wr || r_pend);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt  <= '0;
         r_act  <= DEF_DIV;
         r_shd  <= DEF_DIV;
         r_pend <= 1'b0;
         r_tick <= 1'b0;
         r_cclk <= 1'b0;
      end else begin
         if (i_wr)
            r_shd <= i_val;
         if (w_load) begin
            r_act  <= w_nxt_div;
            r_pend <= 1'b0;
         end else if (i_wr) begin
            r_pend <= 1'b1;
         end
         if (w_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_cclk <= 1'b0;
         end else if (w_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_cclk <= ~r_cclk;
         end else begin
            r_cnt  <= r_cnt + ONE;
            r_tick <= 1'b0;
         end
      end
   end

   assign o_tick = r_tick;
   assign o_cclk = r_cclk;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: tick strobe + 50% clock per channel.
// Ports: sys_clk, sys_rst, ch_en, bus (write/err), tick_o, control_clk.
// CLKDIV_PHASE_SYNC_EN adds phase_sync to realign all enabled channels.
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter int          NUM_CH  = 2,
   parameter int          CNT_W   = 31,
   parameter int unsigned DEF_DIV = CLKDIV_DEF_DIV
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [NUM_CH-1:0] ch_en,
`ifdef CLKDIV_PHASE_SYNC_EN
   input  logic              phase_sync,
`endif
   clkdiv_multi_if.slave     bus,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] control_clk
);

   logic w_bad;
   logic w_ok;
   logic w_sync;
   logic r_err;

   assign w_bad = (bus.div_val == '0) ||
                  (int'(bus.div_ch) >= NUM_CH);
   assign w_ok  = bus.div_wr && !w_bad;

`ifdef CLKDIV_PHASE_SYNC_EN
   assign w_sync = phase_sync;
`else
   assign w_sync = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         r_err <= 1'b0;
      else
         r_err <= bus.div_wr && w_bad;
   end

   assign bus.div_err = r_err;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic w_wr;
      assign w_wr = w_ok && (int'(bus.div_ch) == c);

      clkdiv_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (CNT_W'(DEF_DIV))
      ) u_chan (
         .sys_clk (sys_clk),
         .sys_rst (sys_rst),
         .i_en    (ch_en[c]),
         .i_sync  (w_sync),
         .i_wr    (w_wr),
         .i_val   (bus.div_val),
         .o_tick  (tick_o[c]),
         .o_cclk  (control_clk[c])
      );
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed table-driven bench for clkdiv_multi (3 channels, DEF_DIV=4).
// Phase-sync sequence is built only with CLKDIV_PHASE_SYNC_EN.
module tb_clkdiv_multi;

   localparam int NC = 3;
   localparam int CW = 8;

   typedef struct {
      logic [2:0] en;
      logic       wr;
      logic [1:0] ch;
      logic [7:0] val;
      logic [2:0] t;
      logic [2:0] c;
      logic       e;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NC-1:0] ch_en;
   logic [NC-1:0] tick_o;
   logic [NC-1:0] control_clk;
`ifdef CLKDIV_PHASE_SYNC_EN
   logic          phase_sync;
`endif

   int errors = 0;
   int checks = 0;
   vec_t tv[$];

   clkdiv_multi_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

   clkdiv_multi #(
      .NUM_CH  (NC),
      .CNT_W   (CW),
      .DEF_DIV (4)
   ) dut (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .ch_en       (ch_en),
`ifdef CLKDIV_PHASE_SYNC_EN
      .phase_sync  (phase_sync),
`endif
      .bus         (bus),
      .tick_o      (tick_o),
      .control_clk (control_clk)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [2:0] et,
                        input logic [2:0] ec, input logic ee);
      checks++;
      if (tick_o !== et || control_clk !== ec || bus.div_err !== ee) begin
         errors++;
         $display("FAIL %s: got tick=%b clk=%b err=%b want tick=%b clk=%b err=%b",
                  nm, tick_o, control_clk, bus.div_err, et, ec, ee);
      end
   endtask

   function automatic void add(input logic [2:0] en, input logic wr,
                               input logic [1:0] ch, input logic [7:0] val,
                               input logic [2:0] t, input logic [2:0] c,
                               input logic e);
      vec_t v;
      v.en = en; v.wr = wr; v.ch = ch; v.val = val;
      v.t = t; v.c = c; v.e = e;
      tv.push_back(v);
   endfunction

   initial begin
      rst = 1'b1;
      ch_en = '0;
      bus.div_wr = 1'b0;
      bus.div_ch = '0;
      bus.div_val = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
      phase_sync = 1'b0;
`endif

      // edges 1..12: default divisor 4 on ch0/ch1
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b011, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b011, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b011, 3'b011, 0);
      // 13..25: ch1 <- 3 mid-period
      add(3'b011, 0, 0, 0, 3'b000, 3'b011, 0);
      add(3'b011, 1, 1, 3, 3'b000, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b011, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b010, 0);
      // 26..32: rejected writes
      add(3'b011, 1, 0, 0, 3'b000, 3'b010, 1);
      add(3'b011, 1, 3, 2, 3'b000, 3'b010, 1);
      add(3'b011, 0, 0, 0, 3'b011, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b010, 0);
      // 33..40: ch0 <- 1
      add(3'b011, 1, 0, 1, 3'b000, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b011, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b011, 3'b001, 0);
      // 41..47: ch0 <- 4 on a wrap edge
      add(3'b011, 1, 0, 4, 3'b001, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b001, 0);
      // 48..55: ch0 disabled for 2 edges
      add(3'b010, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b010, 0, 0, 0, 3'b010, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b011, 0);
      // 56..64: back-to-back writes, last wins
      add(3'b011, 1, 1, 5, 3'b000, 3'b011, 0);
      add(3'b011, 1, 1, 2, 3'b001, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b010, 0);
      add(3'b011, 0, 0, 0, 3'b001, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b001, 0);
      add(3'b011, 0, 0, 0, 3'b010, 3'b011, 0);
      // 65..70: pending applied while disabled
      add(3'b011, 1, 1, 3, 3'b001, 3'b010, 0);
      add(3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b000, 0);
      add(3'b011, 0, 0, 0, 3'b011, 3'b011, 0);
      add(3'b011, 0, 0, 0, 3'b000, 3'b011, 0);

      step();
      step();
      check("reset", 3'b000, 3'b000, 1'b0);

      rst = 1'b0;
      foreach (tv[i]) begin
         ch_en = tv[i].en;
         bus.div_wr = tv[i].wr;
         bus.div_ch = tv[i].ch;
         bus.div_val = tv[i].val;
         step();
         check($sformatf("vec%0d", i + 1), tv[i].t, tv[i].c, tv[i].e);
      end
      bus.div_wr = 1'b0;

      // pending write then mid-period reset: pending must be dropped
      bus.div_wr = 1'b1;
      bus.div_ch = 2'd0;
      bus.div_val = 8'd2;
      step();
      bus.div_wr = 1'b0;
      rst = 1'b1;
      step();
      check("midrst", 3'b000, 3'b000, 1'b0);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("postrst%0d", k),
               (k % 4 == 0) ? 3'b011 : 3'b000,
               (k >= 4 && k < 8) ? 3'b011 : 3'b000, 1'b0);
      end

`ifdef CLKDIV_PHASE_SYNC_EN
      bus.div_wr = 1'b1;
      bus.div_ch = 2'd0;
      bus.div_val = 8'd5;
      step();
      bus.div_ch = 2'd1;
      step();
      bus.div_wr = 1'b0;
      ch_en = 3'b000;
      step();
      ch_en = 3'b001;
      for (int j = 3; j <= 9; j++) begin
         if (j == 5)
            ch_en = 3'b011;
         step();
         checks++;
         if (tick_o !== ((j == 7) ? 3'b001 : (j == 9) ? 3'b010 : 3'b000)) begin
            errors++;
            $display("FAIL offset%0d: got tick=%b", j, tick_o);
         end
      end
      phase_sync = 1'b1;
      step();
      phase_sync = 1'b0;
      check("sync", 3'b000, 3'b000, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("aligned%0d", k),
               (k % 5 == 0) ? 3'b011 : 3'b000,
               (k >= 5 && k < 10) ? 3'b011 : 3'b000, 1'b0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
